// File: rtl/digit_argmax.sv
// digit_argmax: captures a vector of class scores and scans it serially for the signed maximum.
module digit_argmax #(
  parameter int CLASS_COUNT = 10,
  parameter int DATA_WIDTH  = 32,
  parameter int IDX_WIDTH   = (CLASS_COUNT > 1) ? $clog2(CLASS_COUNT) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] scores [CLASS_COUNT],
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  class_idx,
  output logic [DATA_WIDTH-1:0] class_score,
  output logic                  no_activation,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t r_state, w_next;
  logic [DATA_WIDTH-1:0] r_snap [CLASS_COUNT];
  logic [DATA_WIDTH-1:0] r_best, r_score, w_best, w_fin_score;
  logic [IDX_WIDTH-1:0]  r_best_idx, r_ptr, r_idx, w_idx, w_fin_idx;
  logic                  r_no_act, w_accept, w_last, w_take, w_fin;
  assign w_accept    = in_valid & in_ready;
  assign w_last      = r_ptr == IDX_WIDTH'(CLASS_COUNT - 1);
  assign w_take      = $signed(r_snap[r_ptr]) > $signed(r_best);
  assign w_best      = w_take ? r_snap[r_ptr] : r_best;
  assign w_idx       = w_take ? r_ptr : r_best_idx;
  // Result registers load on the edge that enters DONE, from either the last compare or a single-class accept.
  assign w_fin       = (r_state == SCAN && w_last) || (w_accept && CLASS_COUNT == 1);
  assign w_fin_score = (r_state == SCAN) ? w_best : scores[0];
  assign w_fin_idx   = (r_state == SCAN) ? w_idx : '0;
  assign in_ready      = r_state == IDLE;
  assign out_valid     = r_state == DONE;
  assign busy          = r_state != IDLE;
  assign class_idx     = r_idx;
  assign class_score   = r_score;
  assign no_activation = r_no_act;
  always_ff @(posedge clk)
    r_state <= !rst_n ? IDLE : w_next;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE) ? (w_accept ? ((CLASS_COUNT == 1) ? DONE : SCAN) : IDLE) :
             (r_state == SCAN) ? (w_last ? DONE : SCAN) :
             (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < CLASS_COUNT; i++) r_snap[i] <= '0;
      r_best     <= '0;
      r_best_idx <= '0;
      r_ptr      <= '0;
      r_score    <= '0;
      r_idx      <= '0;
      r_no_act   <= 1'b0;
    end else begin
      if (w_accept) begin
        for (int i = 0; i < CLASS_COUNT; i++) r_snap[i] <= scores[i];
        r_best     <= scores[0];
        r_best_idx <= '0;
        r_ptr      <= IDX_WIDTH'(1);
      end else if (r_state == SCAN) begin
        r_best     <= w_best;
        r_best_idx <= w_idx;
        r_ptr      <= r_ptr + IDX_WIDTH'(1);
      end
      if (w_fin) begin
        r_score  <= w_fin_score;
        r_idx    <= w_fin_idx;
        r_no_act <= w_fin_score[DATA_WIDTH-1] | ~|w_fin_score;
      end
    end
  end
endmodule

// File: tb/tb_digit_argmax.sv
// tb_digit_argmax: directed vectors with hand-computed argmax results for digit_argmax.
module tb_digit_argmax;
  typedef logic [31:0] vec_t [10];
  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, no_activation, busy;
  logic [31:0] scores [10];
  logic [3:0]  class_idx;
  logic [31:0] class_score;
  int          n_checks = 0;
  int          n_fail = 0;
  digit_argmax dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .scores(scores),
    .out_valid(out_valid), .out_ready(out_ready), .class_idx(class_idx),
    .class_score(class_score), .no_activation(no_activation), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic send(input vec_t v);
    int n;
    vec_t junk;
    for (int i = 0; i < 10; i++) junk[i] = 32'd1000 + 32'(i);
    scores   = v;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      tick;
      n++;
    end
    chk("accept_wait", 64'(n < 50), 64'd1);
    tick;
    in_valid = 1'b0;
    scores   = junk;
  endtask
  task automatic wait_out(input int exp_lat);
    int n;
    n = 0;
    while (!out_valid && n < 50) begin
      tick;
      n++;
    end
    chk("latency", 64'(n), 64'(exp_lat));
  endtask
  task automatic run_vec(input string tag, input vec_t v, input logic [3:0] ei,
                         input logic [31:0] es, input logic ena);
    send(v);
    wait_out(9);
    chk({tag, "_idx"}, 64'(class_idx), 64'(ei));
    chk({tag, "_score"}, 64'(class_score), 64'(es));
    chk({tag, "_noact"}, 64'(no_activation), 64'(ena));
    chk({tag, "_busy"}, 64'(busy), 64'd1);
    tick;
    chk({tag, "_vdrop"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    chk({tag, "_keep"}, 64'(class_score), 64'(es));
  endtask
  vec_t v_main, v_zero, v_neg, v_min, v_bp, v_other, v_abort, v_hi, v_b1, v_b2;
  initial begin
    logic a;
    int   acc [3];
    int   na, nr, seen;
    logic [3:0]  eidx [3];
    logic [31:0] esc [3];
    v_main  = '{32'd3, 32'd9, 32'd2, 32'd7, 32'd9, 32'd0, 32'd1, 32'd4, 32'd5, 32'd8};
    v_zero  = '{default: 32'd0};
    v_neg   = '{-32'sd5, -32'sd2, -32'sd9, -32'sd3, -32'sd4, -32'sd6, -32'sd8, -32'sd10, -32'sd11, -32'sd7};
    v_min   = '{32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'h8000_0000};
    v_bp    = '{32'd4, 32'd4, 32'd4, 32'd60, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4, 32'd4};
    v_other = '{32'd500, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    v_abort = '{32'd1, 32'd2, 32'd77, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9};
    v_hi    = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd100};
    v_b1    = '{32'd5, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd1, 32'd50, 32'd1, 32'd1};
    v_b2    = '{default: 32'd7};
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; scores = v_zero;
    tick; tick;
    rst_n = 1'b1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_idx", 64'(class_idx), 64'd0);
    chk("rst_score", 64'(class_score), 64'd0);
    chk("rst_noact", 64'(no_activation), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    run_vec("main", v_main, 4'd1, 32'd9, 1'b0);
    run_vec("zero", v_zero, 4'd0, 32'd0, 1'b1);
    run_vec("neg", v_neg, 4'd1, 32'hFFFF_FFFE, 1'b1);
    run_vec("minint", v_min, 4'd0, 32'd1, 1'b0);
    // Backpressure: result held while out_ready is low, a competing vector is refused.
    out_ready = 1'b0;
    send(v_bp);
    wait_out(9);
    scores = v_other; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_idx", 64'(class_idx), 64'd3);
      chk("bp_score", 64'(class_score), 64'd60);
      chk("bp_noact", 64'(no_activation), 64'd0);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick;
    chk("bp_rdy_after", 64'(in_ready), 64'd1);
    chk("bp_vdrop", 64'(out_valid), 64'd0);
    chk("bp_busy", 64'(busy), 64'd0);
    chk("bp_keep_idx", 64'(class_idx), 64'd3);
    // Reset during the fourth SCAN cycle abandons the vector.
    send(v_abort);
    tick; tick; tick;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("abort_in_ready", 64'(in_ready), 64'd1);
    chk("abort_idx", 64'(class_idx), 64'd0);
    chk("abort_score", 64'(class_score), 64'd0);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) seen++;
      tick;
    end
    chk("abort_no_result", 64'(seen), 64'd0);
    run_vec("after_abort", v_hi, 4'd9, 32'd100, 1'b0);
    // Back-to-back: in_valid and out_ready held high, accepts every 11 cycles.
    eidx = '{4'd1, 4'd7, 4'd0};
    esc  = '{32'd9, 32'd50, 32'd7};
    na = 0; nr = 0;
    scores = v_main; in_valid = 1'b1;
    for (int c = 0; c < 80 && nr < 3; c++) begin
      a = in_valid && in_ready;
      if (out_valid) begin
        chk("b2b_idx", 64'(class_idx), 64'(eidx[nr]));
        chk("b2b_score", 64'(class_score), 64'(esc[nr]));
        nr++;
      end
      tick;
      if (a) begin
        acc[na] = c;
        na++;
        if (na == 1) scores = v_b1;
        else if (na == 2) scores = v_b2;
        else begin
          in_valid = 1'b0;
          scores = v_other;
        end
      end
    end
    chk("b2b_results", 64'(nr), 64'd3);
    chk("b2b_accepts", 64'(na), 64'd3);
    chk("b2b_gap1", 64'(acc[1] - acc[0]), 64'd11);
    chk("b2b_gap2", 64'(acc[2] - acc[1]), 64'd11);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
